// File: rtl/control_sequencer.sv
// Hardwired Moore control unit driving every Datapath strobe: shared fetch
// (T0-T2), an opcode-specific execute sequence, then back to fetch or HALT.
module control_sequencer #(
    parameter int OPC_LSB = 27
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        BAout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        SHR,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    output logic        run,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_RST, S_HALT, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7
    } state_e;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_RTYPE, C_IMM, C_UNARY, C_JR, C_NOP, C_HALT, C_ILL
    } cls_e;

    // One-hot ALU select, MSB first: ADD SUB AND OR SHR SHL ROR ROL NEG NOT
    localparam logic [9:0] ALU_ADD = 10'b10_0000_0000;
    localparam logic [9:0] ALU_SUB = 10'b01_0000_0000;
    localparam logic [9:0] ALU_AND = 10'b00_1000_0000;
    localparam logic [9:0] ALU_OR  = 10'b00_0100_0000;
    localparam logic [9:0] ALU_SHR = 10'b00_0010_0000;
    localparam logic [9:0] ALU_SHL = 10'b00_0001_0000;
    localparam logic [9:0] ALU_ROR = 10'b00_0000_1000;
    localparam logic [9:0] ALU_ROL = 10'b00_0000_0100;
    localparam logic [9:0] ALU_NEG = 10'b00_0000_0010;
    localparam logic [9:0] ALU_NOT = 10'b00_0000_0001;

    function automatic cls_e classify(input logic [4:0] op);
        case (op)
            5'b00000: classify = C_LD;
            5'b00001: classify = C_LDI;
            5'b00010: classify = C_ST;
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: classify = C_RTYPE;
            5'b01011, 5'b01100, 5'b01101: classify = C_IMM;
            5'b10000, 5'b10001: classify = C_UNARY;
            5'b10011: classify = C_JR;
            5'b11001: classify = C_NOP;
            5'b11010: classify = C_HALT;
            default:  classify = C_ILL;
        endcase
    endfunction

    function automatic logic [9:0] alu_of(input logic [4:0] op);
        case (op)
            5'b00011, 5'b01011: alu_of = ALU_ADD;
            5'b00100:           alu_of = ALU_SUB;
            5'b00101:           alu_of = ALU_SHR;
            5'b00110:           alu_of = ALU_SHL;
            5'b00111:           alu_of = ALU_ROR;
            5'b01000:           alu_of = ALU_ROL;
            5'b01001, 5'b01100: alu_of = ALU_AND;
            5'b01010, 5'b01101: alu_of = ALU_OR;
            5'b10000:           alu_of = ALU_NEG;
            5'b10001:           alu_of = ALU_NOT;
            default:            alu_of = '0;
        endcase
    endfunction

    function automatic state_e last_step(input cls_e c);
        case (c)
            C_LD, C_ST:             last_step = S_T7;
            C_LDI, C_RTYPE, C_IMM:  last_step = S_T5;
            C_UNARY:                last_step = S_T4;
            default:                last_step = S_T3;
        endcase
    endfunction

    state_e     state_q, state_d;
    logic [4:0] op_q, op_d;
    cls_e       cls;
    logic [9:0] alu;
    logic [4:0] ir_opc;
    logic       unused_ir;

    assign ir_opc    = IR[OPC_LSB +: 5];
    assign unused_ir = ^(IR & ~(32'h1F << OPC_LSB));
    assign cls       = classify(op_q);

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= S_RST;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_RST:  state_d = stop ? S_HALT : S_T0;
            S_HALT: state_d = S_HALT;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            default: begin
                if (cls == C_HALT)
                    state_d = S_HALT;
                else if (state_q == last_step(cls))
                    state_d = stop ? S_HALT : S_T0;
                else
                    state_d = state_e'(state_q + 4'd1);
            end
        endcase
        // Opcode is refreshed on every edge that lands in an execute step.
        if (state_d >= S_T3)
            op_d = ir_opc;
    end

    always_comb begin
        {PCout, Zlowout, MDRout, Cout, BAout} = '0;
        {MARin, Zin, PCin, MDRin, IRin, Yin}  = '0;
        {Gra, Grb, Grc, Rin, Rout}            = '0;
        {IncPC, Read, Write, illegal}         = '0;
        alu = '0;
        run = (state_q != S_RST) && (state_q != S_HALT);
        case (state_q)
            S_T0: {PCout, MARin, IncPC, Zin}   = '1;
            S_T1: {Zlowout, PCin, Read, MDRin} = '1;
            S_T2: {MDRout, IRin}               = '1;
            S_T3: begin
                case (cls)
                    C_RTYPE, C_IMM:    {Grb, Rout, Yin}  = '1;
                    C_LD, C_LDI, C_ST: {Grb, BAout, Yin} = '1;
                    C_UNARY: begin
                        {Grb, Rout, Zin} = '1;
                        alu = alu_of(op_q);
                    end
                    C_JR:    {Gra, Rout, PCin} = '1;
                    C_ILL:   illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_RTYPE: begin
                        {Grc, Rout, Zin} = '1;
                        alu = alu_of(op_q);
                    end
                    C_IMM: begin
                        {Cout, Zin} = '1;
                        alu = alu_of(op_q);
                    end
                    C_LD, C_LDI, C_ST: begin
                        {Cout, Zin} = '1;
                        alu = ALU_ADD;
                    end
                    C_UNARY: {Zlowout, Gra, Rin} = '1;
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_RTYPE, C_IMM, C_LDI: {Zlowout, Gra, Rin} = '1;
                    C_LD, C_ST:            {Zlowout, MARin}    = '1;
                    default: ;
                endcase
            end
            S_T6: begin
                if (cls == C_LD)      {Read, MDRin}       = '1;
                else if (cls == C_ST) {Gra, Rout, MDRin}  = '1;
            end
            S_T7: begin
                if (cls == C_LD)      {MDRout, Gra, Rin} = '1;
                else if (cls == C_ST) Write = 1'b1;
            end
            default: ;
        endcase
        {ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT} = alu;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer: per-cycle expected
// strobe vectors plus a hand sequence for asynchronous abort mid-load.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clear, stop;
    logic [31:0] IR;
    logic PCout, Zlowout, MDRout, Cout, BAout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin;
    logic Gra, Grb, Grc, Rin, Rout;
    logic IncPC, Read, Write;
    logic ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT;
    logic run, illegal;

    control_sequencer #(.OPC_LSB(27)) dut (
        .clk(clk), .clear(clear), .IR(IR), .stop(stop),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout), .BAout(BAout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .IncPC(IncPC), .Read(Read), .Write(Write),
        .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHL(SHL),
        .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
        .run(run), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [30:0] obs;
    assign obs = {PCout, Zlowout, MDRout, Cout, BAout, MARin, Zin, PCin, MDRin, IRin, Yin,
                  Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write,
                  ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT, run, illegal};

    localparam logic [30:0] M_PCOUT = 31'h1 << 30, M_ZLO  = 31'h1 << 29, M_MDROUT = 31'h1 << 28;
    localparam logic [30:0] M_COUT  = 31'h1 << 27, M_BA   = 31'h1 << 26, M_MARIN  = 31'h1 << 25;
    localparam logic [30:0] M_ZIN   = 31'h1 << 24, M_PCIN = 31'h1 << 23, M_MDRIN  = 31'h1 << 22;
    localparam logic [30:0] M_IRIN  = 31'h1 << 21, M_YIN  = 31'h1 << 20, M_GRA    = 31'h1 << 19;
    localparam logic [30:0] M_GRB   = 31'h1 << 18, M_GRC  = 31'h1 << 17, M_RIN    = 31'h1 << 16;
    localparam logic [30:0] M_ROUT  = 31'h1 << 15, M_INC  = 31'h1 << 14, M_READ   = 31'h1 << 13;
    localparam logic [30:0] M_WRITE = 31'h1 << 12, M_ADD  = 31'h1 << 11, M_SUB    = 31'h1 << 10;
    localparam logic [30:0] M_OR    = 31'h1 << 8,  M_NEG  = 31'h1 << 3;
    localparam logic [30:0] M_RUN   = 31'h1 << 1,  M_ILL  = 31'h1;

    localparam logic [30:0] F0  = M_PCOUT | M_MARIN | M_INC | M_ZIN | M_RUN;
    localparam logic [30:0] F1  = M_ZLO | M_PCIN | M_READ | M_MDRIN | M_RUN;
    localparam logic [30:0] F2  = M_MDROUT | M_IRIN | M_RUN;
    localparam logic [30:0] R3  = M_GRB | M_ROUT | M_YIN | M_RUN;
    localparam logic [30:0] R5  = M_ZLO | M_GRA | M_RIN | M_RUN;
    localparam logic [30:0] L3  = M_GRB | M_BA | M_YIN | M_RUN;
    localparam logic [30:0] L4  = M_COUT | M_ADD | M_ZIN | M_RUN;
    localparam logic [30:0] L5  = M_ZLO | M_MARIN | M_RUN;
    localparam logic [30:0] L6  = M_READ | M_MDRIN | M_RUN;
    localparam logic [30:0] L7  = M_MDROUT | M_GRA | M_RIN | M_RUN;
    localparam logic [30:0] S6  = M_GRA | M_ROUT | M_MDRIN | M_RUN;
    localparam logic [30:0] S7  = M_WRITE | M_RUN;
    localparam logic [30:0] J3  = M_GRA | M_ROUT | M_PCIN | M_RUN;

    localparam logic [31:0] I_ADD = 32'h1989_0000, I_LD  = 32'h0108_0010, I_JR  = 32'h9A80_0000;
    localparam logic [31:0] I_ST  = 32'h1108_0010, I_ILL = 32'hF800_0000, I_NEG = 32'h8000_0000;
    localparam logic [31:0] I_ORI = 32'h6800_0000, I_SUB = 32'h2000_0000, I_HLT = 32'hD000_0000;

    typedef struct {
        logic        clr;
        logic        stp;
        logic [31:0] ir;
        logic [30:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic vx(input logic c, input logic s, input logic [31:0] i, input logic [30:0] e);
        vec_t r;
        r.clr = c; r.stp = s; r.ir = i; r.exp = e;
        vecs.push_back(r);
    endtask

    task automatic v(input logic [31:0] i, input logic [30:0] e);
        vx(1'b1, 1'b0, i, e);
    endtask

    task automatic check(input string name, input logic [30:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, obs, exp);
        end
    endtask

    task automatic check_invariants(input int row);
        n_checks++;
        if ((Read && Write) || ($countones({ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT}) > 1)) begin
            n_fail++;
            $display("FAIL invariant row %0d: got %08h expected Read/Write exclusive, ALU one-hot", row, obs);
        end
    endtask

    initial begin
        clear = 1'b0; stop = 1'b0; IR = '0;

        // reset, stop at release goes straight to HALT, then a normal release
        vx(0, 0, 0, 0); vx(0, 0, 0, 0);
        vx(1, 1, 0, 0); v(0, 0);
        vx(0, 0, 0, 0);
        v(0, F0);
        // add R3,R1,R2
        v(I_ADD, F1); v(I_ADD, F2); v(I_ADD, R3);
        v(I_ADD, M_GRC | M_ROUT | M_ADD | M_ZIN | M_RUN); v(I_ADD, R5);
        v(I_LD, F0);
        // ld R2,0x10(R1)
        v(I_LD, F1); v(I_LD, F2); v(I_LD, L3); v(I_LD, L4); v(I_LD, L5); v(I_LD, L6); v(I_LD, L7);
        v(I_JR, F0);
        // jr R5
        v(I_JR, F1); v(I_JR, F2); v(I_JR, J3);
        v(I_ST, F0);
        // st
        v(I_ST, F1); v(I_ST, F2); v(I_ST, L3); v(I_ST, L4); v(I_ST, L5); v(I_ST, S6); v(I_ST, S7);
        v(I_ILL, F0);
        // unrecognised opcode 11111
        v(I_ILL, F1); v(I_ILL, F2); v(I_ILL, M_ILL | M_RUN);
        v(I_NEG, F0);
        // neg
        v(I_NEG, F1); v(I_NEG, F2); v(I_NEG, M_GRB | M_ROUT | M_NEG | M_ZIN | M_RUN); v(I_NEG, R5);
        v(I_ORI, F0);
        // ori
        v(I_ORI, F1); v(I_ORI, F2); v(I_ORI, R3); v(I_ORI, M_COUT | M_OR | M_ZIN | M_RUN); v(I_ORI, R5);
        v(I_SUB, F0);
        // sub
        v(I_SUB, F1); v(I_SUB, F2); v(I_SUB, R3); v(I_SUB, M_GRC | M_ROUT | M_SUB | M_ZIN | M_RUN);
        v(I_SUB, R5);
        v(I_ADD, F0);
        // add with stop raised during T4: completes T5, then HALT
        v(I_ADD, F1); v(I_ADD, F2); v(I_ADD, R3); v(I_ADD, M_GRC | M_ROUT | M_ADD | M_ZIN | M_RUN);
        vx(1, 1, I_ADD, R5); vx(1, 1, I_ADD, 0); vx(1, 0, I_ADD, 0);
        // halt instruction, absorbing, then clear pulse
        vx(0, 0, I_HLT, 0);
        v(I_HLT, F0); v(I_HLT, F1); v(I_HLT, F2); v(I_HLT, M_RUN);
        for (int k = 0; k < 10; k++) v(I_HLT, 0);
        vx(0, 0, I_LD, 0);
        v(I_LD, F0);

        for (int r = 0; r < vecs.size(); r++) begin
            clear = vecs[r].clr; stop = vecs[r].stp; IR = vecs[r].ir;
            @(posedge clk); #1;
            check($sformatf("row%0d", r), vecs[r].exp);
            check_invariants(r);
        end

        // clear falling during ld T6 drops Read/MDRin without waiting for an edge
        @(posedge clk); #1; check("abort_T1", F1);
        @(posedge clk); #1; check("abort_T2", F2);
        @(posedge clk); #1; check("abort_T3", L3);
        @(posedge clk); #1; check("abort_T4", L4);
        @(posedge clk); #1; check("abort_T5", L5);
        @(posedge clk); #1; check("abort_T6", L6);
        #2 clear = 1'b0;
        #1 check("abort_async", 0);
        @(posedge clk); #1; check("abort_held", 0);
        clear = 1'b1;
        @(posedge clk); #1; check("abort_restart", F0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit that sits directly upstream of Datapath.
- Drives every Datapath control strobe, replacing hand-sequenced testbench stimulus.
- Runs the shared fetch (T0–T2), then an opcode-specific execute sequence, then returns to fetch.
- Opcode is taken from the Datapath IR output.

Parameters:
OPC_LSB, 27, bit position of the opcode LSB in IR (opcode = IR[31:27], 5 bits)

Ports:
clk  input  1  system clock, all state changes on rising edge
clear  input  1  asynchronous, active-low reset (low forces reset state immediately)
IR  input  32  instruction register contents from Datapath
stop  input  1  request halt at next instruction boundary
PCout, Zlowout, MDRout, Cout, BAout  output  1 each  bus-source strobes
MARin, Zin, PCin, MDRin, IRin, Yin  output  1 each  register load enables
Gra, Grb, Grc, Rin, Rout  output  1 each  register-select/enable strobes
IncPC, Read, Write  output  1 each  PC increment, memory read, memory write
ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT  output  1 each  one-hot ALU op select
run  output  1  high while executing, low in reset and HALT
illegal  output  1  one-cycle pulse in T3 for an unrecognised opcode

Behaviour:
- Moore: every output is a pure decode of the state register, stable for the whole state. Each state lasts exactly one clk.
- Reset (clear=0): state=RST, all outputs 0 including run.
- First rising edge with clear=1: RST->T0 if stop=0, else RST->HALT.
- Mid-operation reset aborts at once. No partial write completes after clear falls.
- Opcodes:
  - ld 00000, ldi 00001, st 00010
  - add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010
  - addi 01011, andi 01100, ori 01101
  - neg 10000, not 10001
  - jr 10011, nop 11001, halt 11010
  - Any other opcode: illegal=1 in T3, then the instruction is treated as nop.
- Fetch (all instructions):
  - T0: PCout MARin IncPC Zin
  - T1: Zlowout PCin Read MDRin
  - T2: MDRout IRin
- Decode: opcode is sampled from IR at the T2->T3 edge and at each execute edge. IR is stable after T2.
- R-type (add..or):
  - T3: Grb Rout Yin
  - T4: Grc Rout op Zin
  - T5: Zlowout Gra Rin
- Immediate (addi/andi/ori):
  - T3: Grb Rout Yin
  - T4: Cout op Zin (ADD/AND/OR respectively)
  - T5: Zlowout Gra Rin
- neg/not:
  - T3: Grb Rout op Zin
  - T4: Zlowout Gra Rin
- ldi:
  - T3: Grb BAout Yin
  - T4: Cout ADD Zin
  - T5: Zlowout Gra Rin
- ld:
  - T3–T4: as ldi
  - T5: Zlowout MARin
  - T6: Read MDRin
  - T7: MDRout Gra Rin
- st:
  - T3–T5: as ld
  - T6: Gra Rout MDRin (Read=0 selects bus into MDR)
  - T7: Write
- jr: T3: Gra Rout PCin.
- nop: T3 with no strobes.
- halt: T3 -> HALT.
- End of execute: last execute state -> T0, or -> HALT if stop=1 at that edge.
- stop is only honoured at instruction boundaries. It never truncates a sequence.
- HALT: all strobes 0, run=0, absorbing until clear=0.
- Exactly one ALU op strobe is high in any state, or none. Write and Read are never high together.
- Instruction length in cycles, fetch included:
  - R-type 6, immediate 6, ldi 6
  - neg/not 5
  - ld 8, st 8
  - jr 4, nop 4

Test Plan:
- clear=0 for 2 cycles, then 1, IR=0 -> all strobes 0 and run=0 during reset; T0 strobes (PCout, MARin, IncPC, Zin) on the first cycle after release; run=1.
- IR=0x19890000 (add R3,R1,R2) -> T3 Grb+Rout+Yin, T4 Grc+Rout+ADD+Zin, T5 Zlowout+Gra+Rin, then T0; 6 cycles total.
- IR=0x01080010 (ld R2,0x10(R1)) -> T3 Grb+BAout+Yin, T4 Cout+ADD+Zin, T5 Zlowout+MARin, T6 Read+MDRin, T7 MDRout+Gra+Rin; 8 cycles.
- IR=0x9A800000 (jr R5) -> T3 Gra+Rout+PCin only, next cycle T0; st variant (opcode 00010) asserts Write only in T7.
- IR=0xD0000000 (halt) -> after T3, run=0 and all strobes 0 for ≥10 cycles; clear pulse returns to T0. Separately, stop=1 during add T4 -> add completes T5, then HALT.
- IR=0xF8000000 (opcode 11111) -> illegal=1 for exactly the T3 cycle, no strobes, next T0. Separately, clear=0 during ld T6 -> Read/MDRin drop immediately, state=RST.
